hazard_ctrl: RTL

Pipeline hazard controller that consumes the ID/EX register outputs and the decode-stage source fields. It drives the hold/bubble/flush controls back into PC, IF/ID, ID/EX and EX/MEM. It resolves load-use stalls, taken branch/jump squashes and multi-cycle data-memory waits. It also keeps saturating stall/flush counters for performance debug.

---
 rtl/hazard_ctrl.sv | 130 +++++++++++++
 1 files changed

// File: rtl/hazard_ctrl.sv
// Pipeline hazard controller: load-use stalls, redirect squashes and data-memory waits,
// with saturating stall/flush counters for performance debug.
module hazard_ctrl #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [4:0]       id_src1,
  input  logic [4:0]       id_src2,
  input  logic             id_uses_src2,
  input  logic             ex_regWrite,
  input  logic             ex_memtoreg,
  input  logic [4:0]       ex_destReg,
  input  logic             ex_redirect,
  input  logic             mem_busy,
  output logic             pc_hold,
  output logic             ifid_hold,
  output logic             idex_hold,
  output logic             exmem_hold,
  output logic             idex_bubble,
  output logic             ifid_flush,
  output logic [1:0]       state,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  localparam logic [1:0] RUN        = 2'd0;
  localparam logic [1:0] LOAD_STALL = 2'd1;
  localparam logic [1:0] MEM_WAIT   = 2'd2;

  logic [1:0]       state_q, state_d;
  logic             flush_pend_q, flush_pend_d;
  logic             load_use;
  logic             hold_pc, hold_ifid, hold_idex, hold_exmem, bubble, flush;
  logic [CNT_W-1:0] stall_q, flush_q;

  assign load_use = ex_memtoreg & ex_regWrite & (ex_destReg != 5'd0) &
                    ((ex_destReg == id_src1) | (id_uses_src2 & (ex_destReg == id_src2)));

  always_comb begin
    hold_pc      = 1'b0;
    hold_ifid    = 1'b0;
    hold_idex    = 1'b0;
    hold_exmem   = 1'b0;
    bubble       = 1'b0;
    flush        = 1'b0;
    state_d      = state_q;
    flush_pend_d = flush_pend_q;
    case (state_q)
      RUN, LOAD_STALL: begin
        if (mem_busy) begin
          hold_pc    = 1'b1;
          hold_ifid  = 1'b1;
          hold_idex  = 1'b1;
          hold_exmem = 1'b1;
          state_d    = MEM_WAIT;
          if (ex_redirect) flush_pend_d = 1'b1;
        end else if (ex_redirect) begin
          flush   = 1'b1;
          bubble  = 1'b1;
          state_d = RUN;
        end else if (state_q == RUN && load_use) begin
          hold_pc   = 1'b1;
          hold_ifid = 1'b1;
          bubble    = 1'b1;
          state_d   = LOAD_STALL;
        end else begin
          state_d = RUN;
        end
      end
      MEM_WAIT: begin
        // EX is frozen here, so a redirect seen now is stale and not sampled.
        if (mem_busy) begin
          hold_pc    = 1'b1;
          hold_ifid  = 1'b1;
          hold_idex  = 1'b1;
          hold_exmem = 1'b1;
        end else if (flush_pend_q) begin
          flush        = 1'b1;
          bubble       = 1'b1;
          flush_pend_d = 1'b0;
          state_d      = RUN;
        end else if (load_use) begin
          hold_pc   = 1'b1;
          hold_ifid = 1'b1;
          bubble    = 1'b1;
          state_d   = LOAD_STALL;
        end else begin
          state_d = RUN;
        end
      end
      default: begin
        state_d      = RUN;
        flush_pend_d = 1'b0;
      end
    endcase
  end

  // Controls are forced low for the whole time reset is held, not just at the edge.
  assign pc_hold     = hold_pc    & rst_n;
  assign ifid_hold   = hold_ifid  & rst_n;
  assign idex_hold   = hold_idex  & rst_n;
  assign exmem_hold  = hold_exmem & rst_n;
  assign idex_bubble = bubble     & rst_n;
  assign ifid_flush  = flush      & rst_n;
  assign state       = state_q;
  assign stall_cnt   = stall_q;
  assign flush_cnt   = flush_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= RUN;
      flush_pend_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      flush_pend_q <= flush_pend_d;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_q <= '0;
      flush_q <= '0;
    end else begin
      if (pc_hold && stall_q != {CNT_W{1'b1}}) stall_q <= stall_q + CNT_W'(1);
      if (ifid_flush && flush_q != {CNT_W{1'b1}}) flush_q <= flush_q + CNT_W'(1);
    end
  end

endmodule
